// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU type definitions: the machine word, the ALU operation encoding
// and the request-unit FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

    // Request-unit FSM: fetching, waiting on the data cache, or halted for good.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } ru_state_t;

endpackage

// File: rtl/request_unit_if.sv
// -----------------------------------------------------------------------------
// request_unit_if
// Bundles the request unit's control-unit / cache-side signals.
//   slave  modport : the request unit itself (consumes ihit/dhit and the
//                    control-unit requests, produces cache requests, pc_en,
//                    halt and stall_cnt).
//   master modport : the surrounding datapath / caches driving the unit.
// Parameter STALL_W : width of stall_cnt.
// -----------------------------------------------------------------------------
interface request_unit_if
    import cpu_types_pkg::*;
#(
    parameter int STALL_W = 16
) ();

    // Inputs to the request unit
    logic               ihit;
    logic               dhit;
    logic               dREN;
    logic               dWEN;
    logic               datomic;
    logic               cpu_halt;
    word_t              dmemaddr;
    word_t              dmemstore;

    // Outputs from the request unit
    logic               imemREN;
    logic               dmemREN;
    logic               dmemWEN;
    logic               dmematomic;
    word_t              dmemaddr_o;
    word_t              dmemstore_o;
    logic               pc_en;
    logic               halt;
    logic [STALL_W-1:0] stall_cnt;

    modport slave (
        input  ihit, dhit, dREN, dWEN, datomic, cpu_halt, dmemaddr, dmemstore,
        output imemREN, dmemREN, dmemWEN, dmematomic, dmemaddr_o, dmemstore_o,
               pc_en, halt, stall_cnt
    );

    modport master (
        output ihit, dhit, dREN, dWEN, datomic, cpu_halt, dmemaddr, dmemstore,
        input  imemREN, dmemREN, dmemWEN, dmematomic, dmemaddr_o, dmemstore_o,
               pc_en, halt, stall_cnt
    );

endinterface

// File: rtl/request_unit.sv
// -----------------------------------------------------------------------------
// request_unit
// Sequences instruction fetch and data-cache access for a single-cycle CPU.
// In IDLE it fetches; an instruction with a data access parks the unit in
// DWAIT with the request registered toward the data cache until dhit; a
// halt parks it in HALTED until reset. pc_en pulses once per committed
// instruction.
// Ports:
//   CLK   : clock, rising edge
//   RST   : asynchronous active-high reset
//   ru_if : request_unit_if.slave (ihit, dhit, dREN, dWEN, datomic, cpu_halt,
//           dmemaddr, dmemstore in; imemREN, dmemREN, dmemWEN, dmematomic,
//           dmemaddr_o, dmemstore_o, pc_en, halt, stall_cnt out)
// Parameter STALL_W : width of the saturating data-stall counter.
// -----------------------------------------------------------------------------
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int STALL_W = 16
) (
    input  logic           CLK,
    input  logic           RST,
    request_unit_if.slave  ru_if
);

    ru_state_t          r_state;
    ru_state_t          w_state_next;
    logic               r_live;        // low from reset until the first edge after release
    logic               r_dmemREN;
    logic               r_dmemWEN;
    logic               r_dmematomic;
    word_t              r_dmemaddr;
    word_t              r_dmemstore;
    logic               r_halt;
    logic [STALL_W-1:0] r_stall_cnt;

    logic               w_data_req;
    logic               w_pc_en;
    logic               w_latch_req;
    logic               w_data_done;
    logic               w_stall_inc;

    assign w_data_req = ru_if.dREN | ru_if.dWEN;

    always_comb begin
        w_state_next = r_state;
        w_pc_en      = 1'b0;
        w_latch_req  = 1'b0;
        w_data_done  = 1'b0;
        w_stall_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                // Fetch is not enabled until r_live, so an ihit before then is ignored.
                if (r_live && ru_if.ihit) begin
                    if (w_data_req) begin
                        w_state_next = DWAIT;
                        w_latch_req  = 1'b1;
                    end else if (ru_if.cpu_halt) begin
                        w_state_next = HALTED;
                    end else begin
                        w_pc_en = 1'b1;
                    end
                end
            end
            DWAIT: begin
                // The instruction is held by the datapath while waiting, so
                // cpu_halt sampled on the dhit cycle belongs to this instruction.
                if (ru_if.dhit) begin
                    w_pc_en      = 1'b1;
                    w_data_done  = 1'b1;
                    w_state_next = ru_if.cpu_halt ? HALTED : IDLE;
                end else begin
                    w_stall_inc = 1'b1;
                end
            end
            HALTED: begin
                w_state_next = HALTED;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_live       <= 1'b0;
            r_dmemREN    <= 1'b0;
            r_dmemWEN    <= 1'b0;
            r_dmematomic <= 1'b0;
            r_dmemaddr   <= '0;
            r_dmemstore  <= '0;
            r_halt       <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            if (w_latch_req) begin
                r_dmemREN    <= ru_if.dREN;
                r_dmemWEN    <= ru_if.dWEN;
                r_dmematomic <= ru_if.datomic;
                r_dmemaddr   <= ru_if.dmemaddr;
                r_dmemstore  <= ru_if.dmemstore;
            end else if (w_data_done) begin
                r_dmemREN    <= 1'b0;
                r_dmemWEN    <= 1'b0;
                r_dmematomic <= 1'b0;
            end
            if (w_state_next == HALTED) begin
                r_halt <= 1'b1;
            end
            // Saturate rather than wrap.
            if (w_stall_inc && (r_stall_cnt != {STALL_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign ru_if.imemREN     = r_live && (r_state == IDLE);
    assign ru_if.pc_en       = w_pc_en;
    assign ru_if.dmemREN     = r_dmemREN;
    assign ru_if.dmemWEN     = r_dmemWEN;
    assign ru_if.dmematomic  = r_dmematomic;
    assign ru_if.dmemaddr_o  = r_dmemaddr;
    assign ru_if.dmemstore_o = r_dmemstore;
    assign ru_if.halt        = r_halt;
    assign ru_if.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_request_unit.sv
// -----------------------------------------------------------------------------
// tb_request_unit
// Directed-vector bench for request_unit. Two instances share all stimulus:
// dut_a with the default 16-bit stall counter and dut_b with a 4-bit counter
// for the saturation case. Inputs change on the falling edge; outputs are
// checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_request_unit;
    import cpu_types_pkg::*;

    logic  clk;
    logic  rst;
    logic  ihit, dhit, dren, dwen, datomic, cpu_halt;
    word_t dmemaddr, dmemstore;

    int n_tests;
    int n_fail;

    request_unit_if #(.STALL_W(16)) ifa ();
    request_unit_if #(.STALL_W(4))  ifb ();

    assign ifa.ihit      = ihit;
    assign ifa.dhit      = dhit;
    assign ifa.dREN      = dren;
    assign ifa.dWEN      = dwen;
    assign ifa.datomic   = datomic;
    assign ifa.cpu_halt  = cpu_halt;
    assign ifa.dmemaddr  = dmemaddr;
    assign ifa.dmemstore = dmemstore;

    assign ifb.ihit      = ihit;
    assign ifb.dhit      = dhit;
    assign ifb.dREN      = dren;
    assign ifb.dWEN      = dwen;
    assign ifb.datomic   = datomic;
    assign ifb.cpu_halt  = cpu_halt;
    assign ifb.dmemaddr  = dmemaddr;
    assign ifb.dmemstore = dmemstore;

    request_unit #(.STALL_W(16)) dut_a (
        .CLK   (clk),
        .RST   (rst),
        .ru_if (ifa.slave)
    );

    request_unit #(.STALL_W(4)) dut_b (
        .CLK   (clk),
        .RST   (rst),
        .ru_if (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    // One cycle of stimulus: drive on the falling edge, settle 1 ns.
    task automatic cyc(input logic ih, input logic dh, input logic r, input logic w,
                       input logic at, input logic hl, input word_t addr, input word_t st);
        @(negedge clk);
        ihit      = ih;
        dhit      = dh;
        dren      = r;
        dwen      = w;
        datomic   = at;
        cpu_halt  = hl;
        dmemaddr  = addr;
        dmemstore = st;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        ihit      = 1'b1;
        dhit      = 1'b0;
        dren      = 1'b0;
        dwen      = 1'b0;
        datomic   = 1'b0;
        cpu_halt  = 1'b0;
        dmemaddr  = 32'h0;
        dmemstore = 32'h0;

        // ---- reset state (ihit held high to show pc_en stays low) ----
        @(negedge clk);
        #1;
        check("rst_imemREN", {31'b0, ifa.imemREN}, 32'd0);
        check("rst_pc_en",   {31'b0, ifa.pc_en},   32'd0);
        check("rst_halt",    {31'b0, ifa.halt},    32'd0);
        check("rst_dmemREN", {31'b0, ifa.dmemREN}, 32'd0);
        check("rst_stall",   {16'b0, ifa.stall_cnt}, 32'd0);
        check("rst_addr_o",  ifa.dmemaddr_o, 32'd0);
        // Release between edges: fetch enable waits for the next rising edge.
        rst  = 1'b0;
        ihit = 1'b0;
        #1;
        check("rel_imemREN_pre", {31'b0, ifa.imemREN}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("rel_imemREN_post", {31'b0, ifa.imemREN}, 32'd1);

        // ---- load: 3 wait cycles, dhit on the 4th ----
        cyc(1, 0, 1, 0, 0, 0, 32'h0000_0040, 32'h0);
        check("ld_issue_pc_en",   {31'b0, ifa.pc_en},   32'd0);
        check("ld_issue_dmemREN", {31'b0, ifa.dmemREN}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, 0, 0, 32'h0000_0040, 32'h0);
            check("ld_wait_dmemREN", {31'b0, ifa.dmemREN}, 32'd1);
            check("ld_wait_imemREN", {31'b0, ifa.imemREN}, 32'd0);
            check("ld_wait_pc_en",   {31'b0, ifa.pc_en},   32'd0);
        end
        check("ld_addr_o", ifa.dmemaddr_o, 32'h0000_0040);
        cyc(1, 1, 1, 0, 0, 0, 32'h0000_0040, 32'h0);
        check("ld_dhit_pc_en",   {31'b0, ifa.pc_en},   32'd1);
        check("ld_dhit_dmemREN", {31'b0, ifa.dmemREN}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("ld_done_dmemREN", {31'b0, ifa.dmemREN}, 32'd0);
        check("ld_done_pc_en",   {31'b0, ifa.pc_en},   32'd0);
        check("ld_done_imemREN", {31'b0, ifa.imemREN}, 32'd1);
        check("ld_stall",        {16'b0, ifa.stall_cnt}, 32'd3);

        // ---- stray dhit in IDLE is ignored ----
        cyc(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        check("idle_dhit_pc_en", {31'b0, ifa.pc_en}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("idle_dhit_imemREN", {31'b0, ifa.imemREN}, 32'd1);
        check("idle_dhit_stall",   {16'b0, ifa.stall_cnt}, 32'd3);

        // ---- non-memory instruction commits immediately ----
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("alu_pc_en", {31'b0, ifa.pc_en}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("alu_pc_en_off", {31'b0, ifa.pc_en}, 32'd0);

        // ---- atomic store: store data changes after issue, latch must hold ----
        cyc(1, 0, 0, 1, 1, 0, 32'h0000_0080, 32'hDEAD_BEEF);
        check("st_issue_pc_en", {31'b0, ifa.pc_en}, 32'd0);
        cyc(1, 0, 0, 1, 1, 0, 32'h0, 32'h0);
        check("st_store_o",   ifa.dmemstore_o, 32'hDEAD_BEEF);
        check("st_addr_o",    ifa.dmemaddr_o,  32'h0000_0080);
        check("st_dmemWEN",   {31'b0, ifa.dmemWEN},    32'd1);
        check("st_atomic",    {31'b0, ifa.dmematomic}, 32'd1);
        check("st_dmemREN",   {31'b0, ifa.dmemREN},    32'd0);
        cyc(1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        check("st_dhit_pc_en", {31'b0, ifa.pc_en},   32'd1);
        check("st_dhit_store", ifa.dmemstore_o,      32'hDEAD_BEEF);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("st_done_dmemWEN", {31'b0, ifa.dmemWEN},    32'd0);
        check("st_done_atomic",  {31'b0, ifa.dmematomic}, 32'd0);
        check("st_stall",        {16'b0, ifa.stall_cnt},  32'd4);

        // ---- read and write together are forwarded as-is ----
        cyc(1, 0, 1, 1, 0, 0, 32'h0000_0100, 32'h1234_5678);
        cyc(1, 1, 1, 1, 0, 0, 32'h0000_0100, 32'h1234_5678);
        check("rw_dmemREN", {31'b0, ifa.dmemREN}, 32'd1);
        check("rw_dmemWEN", {31'b0, ifa.dmemWEN}, 32'd1);
        check("rw_pc_en",   {31'b0, ifa.pc_en},   32'd1);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("rw_stall", {16'b0, ifa.stall_cnt}, 32'd4);

        // ---- halt with a store pending: store completes, one pc_en, then HALTED ----
        cyc(1, 0, 0, 1, 0, 1, 32'h0000_0200, 32'hCAFE_F00D);
        check("hs_issue_pc_en", {31'b0, ifa.pc_en}, 32'd0);
        cyc(1, 0, 0, 1, 0, 1, 32'h0000_0200, 32'hCAFE_F00D);
        check("hs_wait_dmemWEN", {31'b0, ifa.dmemWEN}, 32'd1);
        check("hs_wait_halt",    {31'b0, ifa.halt},    32'd0);
        check("hs_wait_store",   ifa.dmemstore_o,      32'hCAFE_F00D);
        cyc(1, 1, 0, 1, 0, 1, 32'h0000_0200, 32'hCAFE_F00D);
        check("hs_dhit_pc_en", {31'b0, ifa.pc_en}, 32'd1);
        cyc(1, 1, 0, 0, 0, 1, 32'h0, 32'h0);
        check("hs_halt",     {31'b0, ifa.halt},    32'd1);
        check("hs_pc_en",    {31'b0, ifa.pc_en},   32'd0);
        check("hs_imemREN",  {31'b0, ifa.imemREN}, 32'd0);
        check("hs_dmemWEN",  {31'b0, ifa.dmemWEN}, 32'd0);
        check("hs_stall",    {16'b0, ifa.stall_cnt}, 32'd5);
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("hs_sticky_halt",    {31'b0, ifa.halt},    32'd1);
        check("hs_sticky_imemREN", {31'b0, ifa.imemREN}, 32'd0);

        do_reset();
        check("rst2_halt",  {31'b0, ifa.halt},      32'd0);
        check("rst2_stall", {16'b0, ifa.stall_cnt}, 32'd0);

        // ---- plain halt ----
        cyc(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        check("h_pc_en",   {31'b0, ifa.pc_en},   32'd0);
        check("h_halt_pre", {31'b0, ifa.halt},   32'd0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("h_halt",     {31'b0, ifa.halt},    32'd1);
        check("h_imemREN",  {31'b0, ifa.imemREN}, 32'd0);
        check("h_pc_en_ih", {31'b0, ifa.pc_en},   32'd0);
        cyc(1, 0, 1, 0, 0, 0, 32'h0000_0010, 32'h0);
        check("h_no_dmemREN", {31'b0, ifa.dmemREN}, 32'd0);

        do_reset();

        // ---- reset pulsed mid-cycle while waiting on dhit ----
        cyc(1, 0, 1, 0, 1, 0, 32'h0000_0300, 32'h0);
        cyc(1, 1, 1, 0, 1, 0, 32'h0000_0300, 32'h0);
        check("ar_pre_dmemREN", {31'b0, ifa.dmemREN}, 32'd1);
        check("ar_pre_pc_en",   {31'b0, ifa.pc_en},   32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_dmemREN", {31'b0, ifa.dmemREN},    32'd0);
        check("ar_atomic",  {31'b0, ifa.dmematomic}, 32'd0);
        check("ar_pc_en",   {31'b0, ifa.pc_en},      32'd0);
        check("ar_addr_o",  ifa.dmemaddr_o,          32'd0);
        check("ar_imemREN", {31'b0, ifa.imemREN},    32'd0);
        @(negedge clk);
        rst  = 1'b0;
        ihit = 1'b0;
        dhit = 1'b0;
        dren = 1'b0;
        datomic = 1'b0;
        #1;
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("ar_idle_imemREN", {31'b0, ifa.imemREN}, 32'd1);
        check("ar_idle_pc_en",   {31'b0, ifa.pc_en},   32'd1);

        // ---- stall counter saturation (4-bit instance) ----
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cyc(1, 0, 1, 0, 0, 0, 32'h0000_0400, 32'h0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 1, 0, 0, 0, 32'h0000_0400, 32'h0);
        end
        cyc(1, 1, 1, 0, 0, 0, 32'h0000_0400, 32'h0);
        check("sat_b_stall", {28'b0, ifb.stall_cnt}, 32'h0000_000F);
        check("sat_a_stall", {16'b0, ifa.stall_cnt}, 32'd20);
        check("sat_pc_en",   {31'b0, ifb.pc_en},     32'd1);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("sat_b_hold", {28'b0, ifb.stall_cnt}, 32'h0000_000F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
